// File: rtl/or1200_except_sched.sv
// OR1200 exception scheduler: fixed-priority trigger pick, EPCR capture and the flush/drain/resume sequence.
// Optional OR1200_EXCEPT_SCHED_TRAP_FAST_EN lets a TRAP go from FLUSH straight back to IDLE on fetch ack.
//
// state  | meaning
// IDLE   | sampling triggers; no exception in flight
// FLUSH  | pipeline flush requested; waiting for instruction-bus ack
// DRAIN  | fixed settle of FLUSH_CYCLES cycles
// RESUME | waiting for the pipeline to release its stall
module or1200_except_sched #(
    parameter int FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] trig_i,
    input  logic [13:0] mask_i,
    input  logic        dslot_i,
    input  logic [31:0] pc_id_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] pc_wb_i,
    input  logic        fetch_ack_i,
    input  logic        pipe_stall_i,
    output logic        flush_o,
    output logic [3:0]  except_type_o,
    output logic [31:0] epcr_o,
    output logic        epcr_we_o,
    output logic        busy_o
);

`ifdef OR1200_EXCEPT_SCHED_TRAP_FAST_EN
    localparam bit TRAP_FAST = 1'b1;
`else
    localparam bit TRAP_FAST = 1'b0;
`endif

    localparam logic [3:0] TYPE_TRAP = 4'he;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        RESUME = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [13:0] req;
    logic [3:0]  win;
    logic [3:0]  win_type;
    logic        ex_class;
    logic [31:0] epc_sel;

    assign req = trig_i & mask_i & 14'h3ffe;

    // Later (higher) indices override earlier ones, so the highest set bit wins.
    always_comb begin
        win = 4'd0;
        for (int i = 1; i < 14; i++) begin
            if (req[i]) win = 4'(i);
        end
    end

    always_comb begin
        win_type = 4'h0;
        ex_class = 1'b0;
        case (win)
            4'd13: begin win_type = 4'h2; ex_class = 1'b1; end
            4'd12: win_type = 4'h4;
            4'd11: win_type = 4'ha;
            4'd10: begin win_type = 4'h7; ex_class = 1'b1; end
            4'd9:  begin win_type = 4'h6; ex_class = 1'b1; end
            4'd8:  begin win_type = 4'h9; ex_class = 1'b1; end
            4'd7:  begin win_type = 4'he; ex_class = 1'b1; end
            4'd6:  win_type = 4'hc;
            4'd5:  begin win_type = 4'h3; ex_class = 1'b1; end
            4'd4:  begin win_type = 4'hb; ex_class = 1'b1; end
            4'd3:  win_type = 4'hd;
            4'd2:  win_type = 4'h8;
            4'd1:  win_type = 4'h5;
            default: begin win_type = 4'h0; ex_class = 1'b0; end
        endcase
    end

    always_comb begin
        epc_sel = pc_id_i;
        if (dslot_i)       epc_sel = pc_wb_i;
        else if (ex_class) epc_sel = pc_ex_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            except_type_o <= 4'h0;
            epcr_o        <= 32'h0;
            epcr_we_o     <= 1'b0;
        end else begin
            epcr_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 14'h0) begin
                        state         <= FLUSH;
                        except_type_o <= win_type;
                        epcr_o        <= epc_sel;
                        epcr_we_o     <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (fetch_ack_i) begin
                        if (TRAP_FAST && except_type_o == TYPE_TRAP) begin
                            state         <= IDLE;
                            except_type_o <= 4'h0;
                        end else begin
                            state <= DRAIN;
                            cnt   <= 4'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == 4'd0) state <= RESUME;
                    else             cnt   <= cnt - 4'd1;
                end
                RESUME: begin
                    if (!pipe_stall_i) begin
                        state         <= IDLE;
                        except_type_o <= 4'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flush_o = (state == FLUSH);
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_or1200_except_sched.sv
// Directed bench for or1200_except_sched: priority, EPCR source, sequence timing, stall hold and async reset.
module tb_or1200_except_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] trig_i;
    logic [13:0] mask_i;
    logic        dslot_i;
    logic [31:0] pc_id_i, pc_ex_i, pc_wb_i;
    logic        fetch_ack_i;
    logic        pipe_stall_i;
    logic        flush_o;
    logic [3:0]  except_type_o;
    logic [31:0] epcr_o;
    logic        epcr_we_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    int n;

    or1200_except_sched #(.FLUSH_CYCLES(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .trig_i        (trig_i),
        .mask_i        (mask_i),
        .dslot_i       (dslot_i),
        .pc_id_i       (pc_id_i),
        .pc_ex_i       (pc_ex_i),
        .pc_wb_i       (pc_wb_i),
        .fetch_ack_i   (fetch_ack_i),
        .pipe_stall_i  (pipe_stall_i),
        .flush_o       (flush_o),
        .except_type_o (except_type_o),
        .epcr_o        (epcr_o),
        .epcr_we_o     (epcr_we_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until busy_o drops; n is the number of edges taken.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy_o && cnt < 40) begin
            step();
            cnt++;
        end
        check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst = 1'b0; trig_i = '0; mask_i = 14'h3fff; dslot_i = 1'b0;
        pc_id_i = 32'h111; pc_ex_i = 32'h100; pc_wb_i = 32'h222;
        fetch_ack_i = 1'b0; pipe_stall_i = 1'b0;
        #12;
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_type",  32'(except_type_o), 32'd0);
        check("rst_epcr",  epcr_o, 32'd0);
        check("rst_we",    32'(epcr_we_o), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Single ALIGN with ack one cycle after entering FLUSH.
        trig_i = 14'h1 << 9;
        step();
        trig_i = '0;
        check("align_flush", 32'(flush_o), 32'd1);
        check("align_type",  32'(except_type_o), 32'h6);
        check("align_epcr",  epcr_o, 32'h100);
        check("align_we",    32'(epcr_we_o), 32'd1);
        check("align_busy",  32'(busy_o), 32'd1);
        fetch_ack_i = 1'b1;
        step();
        fetch_ack_i = 1'b0;
        check("align_we_pulse", 32'(epcr_we_o), 32'd0);
        check("align_drain_flush", 32'(flush_o), 32'd0);
        wait_idle(n);
        check("align_lat", 32'(n), 32'd4);   // 2 more DRAIN edges, RESUME, IDLE
        check("align_type_clr", 32'(except_type_o), 32'h0);
        check("align_epcr_hold", epcr_o, 32'h100);

        // BUSERR beats INT; INT stays pending and is taken after one IDLE cycle.
        pc_ex_i = 32'h300; pc_id_i = 32'h304;
        trig_i = (14'h1 << 13) | (14'h1 << 2);
        step();
        trig_i = 14'h1 << 2;
        check("prio_type", 32'(except_type_o), 32'h2);
        check("prio_epcr", epcr_o, 32'h300);
        fetch_ack_i = 1'b1; step(); fetch_ack_i = 1'b0;
        wait_idle(n);
        check("prio_idle_gap", 32'(busy_o), 32'd0);
        step();
        trig_i = '0;
        check("int_type", 32'(except_type_o), 32'h8);
        check("int_epcr", epcr_o, 32'h304);
        check("int_we",   32'(epcr_we_o), 32'd1);
        fetch_ack_i = 1'b1; step(); fetch_ack_i = 1'b0;
        wait_idle(n);

        // SYSCALL in delay slot; ack present on the entry edge must not count.
        dslot_i = 1'b1; pc_wb_i = 32'h200;
        trig_i = 14'h1 << 6;
        fetch_ack_i = 1'b1;
        step();
        trig_i = '0; dslot_i = 1'b0; fetch_ack_i = 1'b0;
        check("sys_type", 32'(except_type_o), 32'hc);
        check("sys_epcr", epcr_o, 32'h200);
        step();
        check("sys_still_flush", 32'(flush_o), 32'd1);
        fetch_ack_i = 1'b1; step(); fetch_ack_i = 1'b0;
        check("sys_drain", 32'(flush_o), 32'd0);
        wait_idle(n);

        // Masked TICK and bit 0 are ignored.
        mask_i = 14'h3ffd; trig_i = 14'h1 << 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("tick_masked_busy", 32'(busy_o), 32'd0);
        end
        mask_i = 14'h3fff; trig_i = 14'h1;
        step();
        check("bit0_busy", 32'(busy_o), 32'd0);
        check("bit0_we",   32'(epcr_we_o), 32'd0);
        trig_i = '0;

        // FLOAT with stall held in RESUME for five cycles.
        pc_id_i = 32'h500;
        trig_i = 14'h1 << 3;
        step();
        trig_i = '0;
        check("float_type", 32'(except_type_o), 32'hd);
        check("float_epcr", epcr_o, 32'h500);
        pipe_stall_i = 1'b1;
        fetch_ack_i = 1'b1; step(); fetch_ack_i = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_busy", 32'(busy_o), 32'd1);
            check("stall_type", 32'(except_type_o), 32'hd);
        end
        pipe_stall_i = 1'b0;
        step();
        check("stall_release_busy", 32'(busy_o), 32'd0);
        check("stall_release_type", 32'(except_type_o), 32'h0);

        // TRAP.
        pc_ex_i = 32'h400;
        trig_i = 14'h1 << 7;
        step();
        trig_i = '0;
        check("trap_type", 32'(except_type_o), 32'he);
        check("trap_epcr", epcr_o, 32'h400);
        fetch_ack_i = 1'b1; step(); fetch_ack_i = 1'b0;
`ifdef OR1200_EXCEPT_SCHED_TRAP_FAST_EN
        check("trap_fast_idle", 32'(busy_o), 32'd0);
`else
        wait_idle(n);
        check("trap_lat", 32'(n), 32'd4);
`endif

        // Asynchronous reset while in DRAIN.
        pc_ex_i = 32'h600;
        trig_i = 14'h1 << 9;
        step();
        trig_i = '0;
        fetch_ack_i = 1'b1; step(); fetch_ack_i = 1'b0;
        check("drain_busy", 32'(busy_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_flush", 32'(flush_o), 32'd0);
        check("arst_busy",  32'(busy_o), 32'd0);
        check("arst_type",  32'(except_type_o), 32'h0);
        check("arst_epcr",  epcr_o, 32'h0);
        check("arst_we",    32'(epcr_we_o), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_we",   32'(epcr_we_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
